// File: rtl/bit_serializer16.sv
// Word-to-bit serializer feeding a 16:1 bit-select mux: holds the active word on mux_in
// and steps mux_sel one bit per accepted beat, with a one-word pending buffer behind it.
module bit_serializer16 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    input  logic [4:0]  len_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [15:0] mux_in,
    output logic [3:0]  mux_sel,
    output logic        bit_valid,
    output logic        bit_last,
    input  logic        bit_ready,
    output logic        busy
);

    // state    | meaning
    // S_IDLE   | active empty, pending empty
    // S_RUN    | active full, pending empty
    // S_RUN_FULL | active full, pending full
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_RUN_FULL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_act_word;
    logic [4:0]  r_act_len;
    logic [3:0]  r_idx;
    logic [15:0] r_pend_word;
    logic [4:0]  r_pend_len;

    logic [4:0]  w_len_norm;
    logic [4:0]  w_len_m1;
    logic        w_word_xfer;
    logic        w_bit_xfer;
    logic        w_last_xfer;
    logic        w_load_in;
    logic        w_load_pend;
    logic        w_pend_to_act;
    logic        w_idx_inc;
    logic        w_go_idle;

    // 0 and anything above 16 both mean a full 16-bit word
    assign w_len_norm = ((len_in == 5'd0) || (len_in > 5'd16)) ? 5'd16 : len_in;
    assign w_len_m1   = r_act_len - 5'd1;

    assign word_ready = (r_state != S_RUN_FULL);
    assign bit_valid  = (r_state != S_IDLE);
    assign bit_last   = bit_valid && (r_idx == w_len_m1[3:0]);
    assign busy       = (r_state != S_IDLE);
    assign mux_in     = r_act_word;
    assign mux_sel    = MSB_FIRST ? (4'd15 - r_idx) : r_idx;

    assign w_word_xfer = word_valid & word_ready;
    assign w_bit_xfer  = bit_valid & bit_ready;
    assign w_last_xfer = w_bit_xfer & bit_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_in     = 1'b0;
        w_load_pend   = 1'b0;
        w_pend_to_act = 1'b0;
        w_idx_inc     = 1'b0;
        w_go_idle     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_word_xfer) begin
                    w_load_in   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_xfer) begin
                    if (w_word_xfer) begin
                        w_load_in = 1'b1;
                    end else begin
                        w_go_idle   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_idx_inc = w_bit_xfer;
                    if (w_word_xfer) begin
                        w_load_pend = 1'b1;
                        w_state_nxt = S_RUN_FULL;
                    end
                end
            end
            S_RUN_FULL: begin
                if (w_last_xfer) begin
                    w_pend_to_act = 1'b1;
                    w_state_nxt   = S_RUN;
                end else begin
                    w_idx_inc = w_bit_xfer;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_word  <= 16'h0000;
            r_act_len   <= 5'd16;
            r_idx       <= 4'd0;
            r_pend_word <= 16'h0000;
            r_pend_len  <= 5'd16;
        end else begin
            if (w_load_in) begin
                r_act_word <= word_in;
                r_act_len  <= w_len_norm;
                r_idx      <= 4'd0;
            end else if (w_pend_to_act) begin
                r_act_word <= r_pend_word;
                r_act_len  <= r_pend_len;
                r_idx      <= 4'd0;
            end else if (w_go_idle) begin
                r_idx <= 4'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_load_pend) begin
                r_pend_word <= word_in;
                r_pend_len  <= w_len_norm;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer16.sv
// Directed bench for bit_serializer16: LSB-first and MSB-first instances share stimulus;
// the serial bit is reconstructed as mux_in[mux_sel], as the downstream mux would.
module tb_bit_serializer16;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_in;
    logic [4:0]  len_in;
    logic        word_valid;
    logic        bit_ready;

    logic        word_ready0, word_ready1;
    logic [15:0] mux_in0, mux_in1;
    logic [3:0]  mux_sel0, mux_sel1;
    logic        bit_valid0, bit_valid1;
    logic        bit_last0, bit_last1;
    logic        busy0, busy1;

    int n_vec;
    int n_fail;

    bit_serializer16 #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .len_in(len_in),
        .word_valid(word_valid), .word_ready(word_ready0), .mux_in(mux_in0),
        .mux_sel(mux_sel0), .bit_valid(bit_valid0), .bit_last(bit_last0),
        .bit_ready(bit_ready), .busy(busy0)
    );

    bit_serializer16 #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .len_in(len_in),
        .word_valid(word_valid), .word_ready(word_ready1), .mux_in(mux_in1),
        .mux_sel(mux_sel1), .bit_valid(bit_valid1), .bit_last(bit_last1),
        .bit_ready(bit_ready), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        msb;
        logic [15:0] word;
        logic [4:0]  len;
        int          beats;
        logic [15:0] stream;
        logic        stall;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one word, then drain it; stream[k] collects the k-th serial bit.
    task automatic run_word(input logic msb, input logic [15:0] w, input logic [4:0] l,
                            input int nb, input logic [15:0] exp_stream, input logic stall);
        logic [15:0] got;
        logic [5:0]  pat;
        logic [3:0]  s, psel, esel;
        logic        v, la, b, br, plast, pstall;
        int          k, cyc;
        got = '0; k = 0; cyc = 0; pstall = 1'b0; psel = '0; plast = 1'b0;
        pat = 6'b101001;
        @(negedge clk);
        word_in = w; len_in = l; word_valid = 1'b1; bit_ready = 1'b0;
        @(negedge clk);
        word_valid = 1'b0;
        while (k < nb && cyc < 200) begin
            s  = msb ? mux_sel1 : mux_sel0;
            v  = msb ? bit_valid1 : bit_valid0;
            la = msb ? bit_last1 : bit_last0;
            b  = msb ? mux_in1[mux_sel1] : mux_in0[mux_sel0];
            if (pstall) begin
                check("stall_sel", {28'd0, s}, {28'd0, psel});
                check("stall_last", {31'd0, la}, {31'd0, plast});
            end
            br = stall ? pat[cyc % 6] : 1'b1;
            bit_ready = br;
            if (!v) begin
                check("bit_valid_mid_word", {31'd0, v}, 32'd1);
            end else if (br) begin
                esel = msb ? 4'(15 - k) : 4'(k);
                check("beat_sel", {28'd0, s}, {28'd0, esel});
                check("beat_last", {31'd0, la}, {31'd0, (k == nb - 1)});
                got[k] = b;
                k++;
            end
            pstall = v & ~br;
            psel   = s;
            plast  = la;
            cyc++;
            @(negedge clk);
        end
        bit_ready = 1'b0;
        check("beat_count", k, nb);
        check("stream", {16'd0, got}, {16'd0, exp_stream});
        check("idle_after", {31'd0, (msb ? bit_valid1 : bit_valid0)}, 32'd0);
    endtask

    initial begin
        logic [15:0] ws[3];
        int          acc[3];
        logic [11:0] got12, last12;
        int          wi, k, first_cyc, last_cyc;
        logic        rdy;

        n_vec = 0; n_fail = 0;
        rst_n = 1'b0; word_in = '0; len_in = '0; word_valid = 1'b0; bit_ready = 1'b0;

        vecs[0] = '{1'b0, 16'hA5C3, 5'd16, 16, 16'hA5C3, 1'b0};
        vecs[1] = '{1'b0, 16'hA5C3, 5'd16, 16, 16'hA5C3, 1'b1};
        vecs[2] = '{1'b0, 16'h0001, 5'd1,  1,  16'h0001, 1'b0};
        vecs[3] = '{1'b0, 16'h1234, 5'd0,  16, 16'h1234, 1'b0};
        vecs[4] = '{1'b0, 16'h1234, 5'd20, 16, 16'h1234, 1'b0};
        vecs[5] = '{1'b0, 16'hFFFF, 5'd5,  5,  16'h001F, 1'b1};
        vecs[6] = '{1'b1, 16'h8001, 5'd16, 16, 16'h8001, 1'b0};
        vecs[7] = '{1'b1, 16'hC000, 5'd3,  3,  16'h0003, 1'b0};
        vecs[8] = '{1'b1, 16'h4002, 5'd31, 16, 16'h4002, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_bit_valid", {31'd0, bit_valid0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_mux_in", {16'd0, mux_in0}, 32'd0);
        check("rst_sel_lsb", {28'd0, mux_sel0}, 32'd0);
        check("rst_sel_msb", {28'd0, mux_sel1}, 32'd15);
        check("rst_last", {31'd0, bit_last0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_word_ready", {31'd0, word_ready0}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_word(vecs[i].msb, vecs[i].word, vecs[i].len, vecs[i].beats,
                     vecs[i].stream, vecs[i].stall);
        end

        // Back-to-back: three 4-bit words offered continuously, no bubbles expected.
        ws[0] = 16'h000F; ws[1] = 16'h00F0; ws[2] = 16'h0F00;
        acc[0] = -1; acc[1] = -1; acc[2] = -1;
        wi = 0; k = 0; got12 = '0; last12 = '0; first_cyc = -1; last_cyc = -1;
        @(negedge clk);
        bit_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 12; cyc++) begin
            word_valid = (wi < 3);
            word_in    = (wi < 3) ? ws[wi] : 16'h0000;
            len_in     = 5'd4;
            rdy = word_ready0;
            if (cyc >= 2 && cyc <= 4) check("b2b_ready_low", {31'd0, rdy}, 32'd0);
            if (word_valid && rdy) begin
                acc[wi] = cyc;
                wi++;
            end
            if (bit_valid0) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                check("b2b_sel", {28'd0, mux_sel0}, k % 4);
                got12[k]  = mux_in0[mux_sel0];
                last12[k] = bit_last0;
                k++;
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
        bit_ready  = 1'b0;
        check("b2b_acc1", acc[0], 0);
        check("b2b_acc2", acc[1], 1);
        check("b2b_acc3", acc[2], 5);
        check("b2b_beats", k, 12);
        check("b2b_span", last_cyc - first_cyc, 11);
        check("b2b_bits", {20'd0, got12}, 32'h00F);
        check("b2b_lasts", {20'd0, last12}, 32'h888);
        check("b2b_idle", {31'd0, bit_valid0}, 32'd0);
        check("b2b_busy", {31'd0, busy0}, 32'd0);

        // Reset mid-word with a word pending.
        @(negedge clk);
        word_in = 16'hA5C3; len_in = 5'd16; word_valid = 1'b1; bit_ready = 1'b1;
        @(negedge clk);
        word_in = 16'h1111;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_sel", {28'd0, mux_sel0}, 32'd5);
        check("pre_rst_ready", {31'd0, word_ready0}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bit_valid", {31'd0, bit_valid0}, 32'd0);
        check("arst_busy", {31'd0, busy0}, 32'd0);
        check("arst_mux_in", {16'd0, mux_in0}, 32'd0);
        check("arst_sel_lsb", {28'd0, mux_sel0}, 32'd0);
        check("arst_sel_msb", {28'd0, mux_sel1}, 32'd15);
        check("arst_last", {31'd0, bit_last0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {31'd0, bit_valid0 | busy0}, 32'd0);
        end
        run_word(1'b0, 16'h0006, 5'd2, 2, 16'h0002, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
